// File: rtl/vr_vc_converter.sv
// ----------------------------------------------------------------------------
// vr_vc_converter
//   Bridges a valid/ready upstream to a credit-based downstream.
//   The downstream receiver grants CREDIT_NUM buffer slots. Each accepted
//   beat spends one credit; each m_credit_i pulse returns one. When no credit
//   is left the block stalls upstream by dropping s_ready_o.
//
// Handshake semantics:
//   Upstream (valid/ready): a beat transfers in any cycle where s_valid_i and
//   s_ready_o are both high. s_ready_o depends only on registered state, so
//   upstream may look at it without creating a combinational loop. s_data_i
//   is sampled only in the transfer cycle.
//   Downstream (valid/credit): m_valid_o is a one-cycle pulse per beat,
//   qualifying m_data_o. m_credit_i is a one-cycle pulse per freed slot.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   s_data_i       upstream payload
//   s_valid_i      upstream valid
//   s_ready_o      upstream ready (credit available and no error)
//   m_data_o       downstream payload, held between beats
//   m_valid_o      downstream valid pulse
//   m_credit_i     credit return pulse
//   credit_cnt_o   credits currently available
//   err_o          sticky credit-overflow flag, cleared only by reset
// ----------------------------------------------------------------------------
module vr_vc_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           s_data_i,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_valid_o,
  input  logic                            m_credit_i,
  output logic [$clog2(CREDIT_NUM+1)-1:0] credit_cnt_o,
  output logic                            err_o
);

  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_NUM);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [CW-1:0] credit_cnt;
  logic          err;
  logic          accept;

  // Ready is a pure decode of registered state; no input feeds it.
  assign s_ready_o    = (credit_cnt != '0) && !err;
  assign accept       = s_valid_i && s_ready_o;
  assign credit_cnt_o = credit_cnt;
  assign err_o        = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      credit_cnt <= CREDIT_MAX;
      err        <= 1'b0;
    end else begin
      m_valid_o <= accept;
      if (accept) begin
        m_data_o <= s_data_i;
      end

      // A simultaneous spend and return cancel out, so only the two
      // one-sided cases touch the counter.
      unique case ({accept, m_credit_i})
        2'b10: credit_cnt <= credit_cnt - ONE;
        2'b01: begin
          // A return with every credit already home means the downstream
          // miscounted: saturate and latch the error.
          if (credit_cnt == CREDIT_MAX) begin
            err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vr_vc_converter.md
VR_VC_CONVERTER -- requirements
Module: vr_vc_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter CREDIT_NUM, default 2, credits granted by the downstream receiver; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_data_i  input  DATA_WIDTH  upstream payload.
REQ-006 SHALL have port s_valid_i  input  1  upstream valid.
REQ-007 SHALL have port s_ready_o  output  1  upstream ready.
REQ-008 SHALL have port m_data_o  output  DATA_WIDTH  downstream payload.
REQ-009 SHALL have port m_valid_o  output  1  downstream valid; one-cycle pulse per beat.
REQ-010 SHALL have port m_credit_i  input  1  one-cycle pulse; each high cycle returns one credit.
REQ-011 SHALL have port credit_cnt_o  output  $clog2(CREDIT_NUM+1)  credits currently available.
REQ-012 SHALL have port err_o  output  1  sticky flag set by credit overflow.

Function
REQ-013 SHALL keep a credit counter of width $clog2(CREDIT_NUM+1), loaded with CREDIT_NUM by reset; credit_cnt_o SHALL equal it.
REQ-014 SHALL drive s_ready_o = (credit counter != 0) AND NOT err_o, decoded only from registered state, with no combinational path from any input.
REQ-015 SHALL accept an upstream beat in a cycle where s_valid_i and s_ready_o are both high ("accept").
REQ-016 On accept, SHALL register s_data_i into m_data_o and assert m_valid_o for exactly the next cycle: latency 1 cycle, one m_valid_o pulse per accept.
REQ-017 In a cycle with no accept, SHALL drive m_valid_o low on the next cycle and SHALL hold m_data_o at its last value.
REQ-018 SHALL decrement the counter by 1 on accept without credit return.
REQ-019 SHALL increment the counter by 1 on m_credit_i high without accept.
REQ-020 SHALL leave the counter unchanged when accept and m_credit_i occur in the same cycle.
REQ-021 Back-to-back accepts SHALL be sustained at 1 beat/cycle while credits remain; with the counter at 1, an accept without credit return SHALL deassert s_ready_o the next cycle.
REQ-022 With the counter at 0 and m_credit_i high, s_ready_o SHALL rise in the next cycle; there is no bypass in the same cycle.
REQ-023 With the counter at CREDIT_NUM, m_credit_i high and no accept, the counter SHALL saturate at CREDIT_NUM and err_o SHALL set.
REQ-024 err_o SHALL remain set until reset; while set, s_ready_o SHALL be 0 and no new beats SHALL be accepted.
REQ-025 Upstream holding s_valid_i high with s_ready_o low SHALL cause no state change; data SHALL be taken only on the accept cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately, without a clock, force m_valid_o=0, m_data_o=0, err_o=0 and the counter to CREDIT_NUM.
REQ-027 With rst_n low, s_ready_o SHALL be 1 and SHALL be ignored by upstream; no accept SHALL occur during reset.
REQ-028 Reset mid-transfer SHALL discard any pending m_valid_o pulse; credits consumed before reset SHALL be considered restored, and downstream SHALL be reset together with this block.
REQ-029 Deassertion of rst_n SHALL take effect on the first rising clk edge after release; the first accept is possible in that cycle.

Verification (CREDIT_NUM=2, DATA_WIDTH=8)
REQ-030 Reset check: rst_n=0 mid-cycle -> m_valid_o=0, m_data_o=8'h00, credit_cnt_o=2, err_o=0 before the next edge.
REQ-031 Single beat: s_valid_i=1, s_data_i=8'hAA for one cycle -> next cycle m_valid_o=1, m_data_o=8'hAA, credit_cnt_o=1; the following cycle m_valid_o=0.
REQ-032 Credit exhaustion: beats 8'hBB and 8'hCC back-to-back, no credits, s_valid_i held high with 8'hDD -> two m_valid_o pulses, credit_cnt_o=0, s_ready_o=0, 8'hDD not emitted.
REQ-033 Credit return: from the REQ-032 state, one m_credit_i pulse -> credit_cnt_o=1 and s_ready_o=1 the next cycle, 8'hDD accepted, m_valid_o with 8'hDD one cycle after that.
REQ-034 Simultaneous events: with credit_cnt_o=1, accept 8'hEE in the same cycle as an m_credit_i pulse -> credit_cnt_o stays 1 and m_valid_o with 8'hEE follows.
REQ-035 Overflow: at credit_cnt_o=2 with idle upstream, m_credit_i pulse -> err_o=1, credit_cnt_o=2, s_ready_o=0 until rst_n pulse, then err_o=0 and s_ready_o=1.
